// File: rtl/seq_shift_add_mult_if.sv
// Operand/result bundle for the sequential shift-and-add multiplier.
// The producer of operands uses master; the multiplier uses slave.
interface seq_shift_add_mult_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/seq_shift_add_mult.sv
// Unsigned WIDTH x WIDTH shift-and-add multiplier: one ripple-carry add and
// one right shift per cycle, 2*WIDTH-bit product after WIDTH iterations.
module seq_shift_add_mult #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_shift_add_mult_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     acc_hi;
    logic [WIDTH-1:0]     acc_lo;
    logic [CNT_W-1:0]     count;
    logic                 busy_r;
    logic                 done_r;
    logic [2*WIDTH-1:0]   product_r;

    logic [WIDTH-1:0]     addend;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   shifted;

    // Ripple-carry adder returning {carry_out, sum}.
    function automatic logic [WIDTH:0] rca_add(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic             cin
    );
        logic [WIDTH-1:0] s;
        logic             c;
        c = cin;
        for (int i = 0; i < WIDTH; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, s};
    endfunction

    // Iteration datapath: the carry-out lands in the top bit after the shift.
    always_comb begin
        addend  = acc_lo[0] ? mcand : '0;
        sum     = rca_add(acc_hi, addend, 1'b0);
        shifted = {sum, acc_lo[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            product_r <= '0;
            mcand     <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            count     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        mcand  <= bus.a;
                        acc_hi <= '0;
                        acc_lo <= bus.b;
                        count  <= '0;
                        busy_r <= 1'b1;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    {acc_hi, acc_lo} <= shifted;
                    count            <= count + 1'b1;
                    if (count == LAST_STEP) begin
                        product_r <= shifted;
                        done_r    <= 1'b1;
                        busy_r    <= 1'b0;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_r <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.product = product_r;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Self-checking bench: one multiplier per WIDTH 2..8, checked cycle by cycle
// against a plain a*b reference and the expected start-to-done timing.
module tb_seq_shift_add_mult;

    logic              clk;
    logic              rst;
    logic [8:2]        start_v;
    logic [8:2][7:0]   a_v;
    logic [8:2][7:0]   b_v;
    logic [8:2]        busy_v;
    logic [8:2]        done_v;
    logic [8:2][15:0]  prod_v;

    logic [15:0]       model_prod [2:8];
    int                n_tests;
    int                n_fail;

    for (genvar w = 2; w <= 8; w++) begin : g
        seq_shift_add_mult_if #(.WIDTH(w)) bus ();
        assign bus.start  = start_v[w];
        assign bus.a      = a_v[w][w-1:0];
        assign bus.b      = b_v[w][w-1:0];
        assign busy_v[w]  = bus.busy;
        assign done_v[w]  = bus.done;
        assign prod_v[w]  = 16'(bus.product);
        seq_shift_add_mult #(.WIDTH(w)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_v = '0;
        a_v = '0;
        b_v = '0;
        tick();
        tick();
        n_tests++;
        if ({busy_v, done_v} !== 14'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy=%b done=%b, expected all 0", busy_v, done_v);
        end
        n_tests++;
        if (prod_v !== '0) begin
            n_fail++;
            $display("FAIL reset_product: product=%h, expected 0", prod_v);
        end
        rst = 1'b0;
        for (int w = 2; w <= 8; w++) model_prod[w] = '0;
        tick();
    endtask

    // Full operation on width w: product must hold the old value until done.
    task automatic test_basic(input int w, input logic [7:0] op_a,
                              input logic [7:0] op_b, input string tag);
        logic [7:0]  mask;
        logic [15:0] exp_p;
        logic [15:0] old_p;
        mask  = 8'((1 << w) - 1);
        exp_p = 16'(op_a & mask) * 16'(op_b & mask);
        old_p = model_prod[w];
        start_v[w] = 1'b1;
        a_v[w] = op_a & mask;
        b_v[w] = op_b & mask;
        tick();
        start_v[w] = 1'b0;
        a_v[w] = 8'($urandom);
        b_v[w] = 8'($urandom);
        for (int i = 0; i < w; i++) begin
            n_tests++;
            if ({busy_v[w], done_v[w], prod_v[w]} !== {2'b10, old_p}) begin
                n_fail++;
                $display("FAIL %s_run w=%0d step=%0d: busy=%b done=%b product=%h, expected busy=1 done=0 product=%h",
                         tag, w, i, busy_v[w], done_v[w], prod_v[w], old_p);
            end
            tick();
        end
        n_tests++;
        if ({busy_v[w], done_v[w], prod_v[w]} !== {2'b01, exp_p}) begin
            n_fail++;
            $display("FAIL %s_done w=%0d a=%0d b=%0d: busy=%b done=%b product=%h, expected busy=0 done=1 product=%h",
                     tag, w, op_a & mask, op_b & mask, busy_v[w], done_v[w], prod_v[w], exp_p);
        end
        tick();
        n_tests++;
        if ({busy_v[w], done_v[w], prod_v[w]} !== {2'b00, exp_p}) begin
            n_fail++;
            $display("FAIL %s_hold w=%0d: busy=%b done=%b product=%h, expected busy=0 done=0 product=%h",
                     tag, w, busy_v[w], done_v[w], prod_v[w], exp_p);
        end
        model_prod[w] = exp_p;
    endtask

    task automatic test_zero();
        test_basic(4, 8'd0, 8'd9, "zero_a");
        test_basic(4, 8'd9, 8'd0, "zero_b");
    endtask

    task automatic test_ignore_start();
        start_v[4] = 1'b1;
        a_v[4] = 8'd6;
        b_v[4] = 8'd7;
        tick();
        start_v[4] = 1'b0;
        tick();
        start_v[4] = 1'b1;
        a_v[4] = 8'd1;
        b_v[4] = 8'd1;
        tick();
        start_v[4] = 1'b0;
        n_tests++;
        if ({busy_v[4], done_v[4]} !== 2'b10) begin
            n_fail++;
            $display("FAIL ignore_run: busy=%b done=%b, expected busy=1 done=0", busy_v[4], done_v[4]);
        end
        tick();
        tick();
        n_tests++;
        if ({done_v[4], prod_v[4]} !== {1'b1, 16'd42}) begin
            n_fail++;
            $display("FAIL ignore_done: done=%b product=%0d, expected done=1 product=42", done_v[4], prod_v[4]);
        end
        start_v[4] = 1'b1;
        tick();
        start_v[4] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_tests++;
            if ({busy_v[4], done_v[4], prod_v[4]} !== {2'b00, 16'd42}) begin
                n_fail++;
                $display("FAIL ignore_idle cycle=%0d: busy=%b done=%b product=%0d, expected busy=0 done=0 product=42",
                         i, busy_v[4], done_v[4], prod_v[4]);
            end
        end
        model_prod[4] = 16'd42;
        test_basic(4, 8'd1, 8'd1, "idle_start");
    endtask

    task automatic test_reset_mid();
        start_v[4] = 1'b1;
        a_v[4] = 8'd13;
        b_v[4] = 8'd11;
        tick();
        start_v[4] = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if ({busy_v[4], done_v[4], prod_v[4]} !== 18'b0) begin
            n_fail++;
            $display("FAIL abort_reset: busy=%b done=%b product=%h, expected all 0", busy_v[4], done_v[4], prod_v[4]);
        end
        for (int w = 2; w <= 8; w++) model_prod[w] = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_tests++;
            if ({busy_v[4], done_v[4], prod_v[4]} !== 18'b0) begin
                n_fail++;
                $display("FAIL abort_quiet cycle=%0d: busy=%b done=%b product=%h, expected all 0",
                         i, busy_v[4], done_v[4], prod_v[4]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int          n_done;
        int          done_c [4];
        logic [15:0] done_p [4];
        n_done = 0;
        start_v[8] = 1'b1;
        a_v[8] = 8'd255;
        b_v[8] = 8'd255;
        tick();
        a_v[8] = 8'd128;
        b_v[8] = 8'd2;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (done_v[8] === 1'b1) begin
                if (n_done < 4) begin
                    done_c[n_done] = c;
                    done_p[n_done] = prod_v[8];
                end
                n_done++;
            end
        end
        start_v[8] = 1'b0;
        n_tests++;
        if (n_done !== 2) begin
            n_fail++;
            $display("FAIL b2b_count: %0d done pulses, expected 2", n_done);
        end
        if (n_done >= 2) begin
            n_tests++;
            if ({done_c[0], done_c[1]} !== {32'd8, 32'd18}) begin
                n_fail++;
                $display("FAIL b2b_timing: done at cycles %0d,%0d, expected 8,18", done_c[0], done_c[1]);
            end
            n_tests++;
            if ({done_p[0], done_p[1]} !== {16'hFE01, 16'h0100}) begin
                n_fail++;
                $display("FAIL b2b_product: got %h,%h, expected fe01,0100", done_p[0], done_p[1]);
            end
        end
        for (int i = 0; i < 12; i++) tick();
        model_prod[8] = 16'h0100;
    endtask

    task automatic test_random();
        for (int w = 2; w <= 8; w++) begin
            test_basic(w, 8'hFF, 8'hFF, "max");
            for (int r = 0; r < 6; r++)
                test_basic(w, 8'($urandom), 8'($urandom), "rand");
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        test_reset();
        test_basic(4, 8'd3, 8'd5, "basic");
        test_basic(4, 8'd15, 8'd15, "all_ones");
        test_zero();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
